serial_subtractor: RTL
======================

// Module: serial_subtractor
// PURPOSE
//   Multi-cycle unsigned subtractor: diff = a - b - bin over WIDTH bits, processed LSB-first
//   DIGIT bits per cycle through a digit-wide full-subtractor cell and a registered borrow.
//   Trades latency for area in datapaths that need wide subtraction without a wide ripple chain.
//   Ready/valid on input and output; one operation in flight.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; must be >= 1
//   DIGIT  1  bits processed per cycle; must divide WIDTH (STEPS = WIDTH/DIGIT)
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operands valid
//   in_ready   out  1      block accepts operands (IDLE only)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in applied at bit 0
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      downstream accepts result
//   diff       out  WIDTH  result, (a - b - bin) mod 2^WIDTH
//   bout       out  1      final borrow-out (1 = a < b + bin)
//   busy       out  1      1 in RUN or DONE
// BEHAVIOUR
//   - Reset (rst=1 at edge): state=IDLE, step count=0, borrow=0, diff=0, bout=0, out_valid=0;
//     in_ready=1 from first cycle after reset. Reset mid-RUN/DONE aborts; no result emitted.
//   - FSM IDLE: in_ready=1. in_valid=1 at edge -> latch a, b, borrow<=bin, count<=0 -> RUN.
//   - FSM RUN: in_ready=0. Each edge: digit cell subtracts a_sh[DIGIT-1:0] - b_sh[DIGIT-1:0]
//     - borrow; result digit shifted into diff shift register from MSB end; a_sh/b_sh shift
//     right by DIGIT; borrow <= digit borrow-out; count++. On count==STEPS-1 -> DONE.
//   - FSM DONE: out_valid=1; diff, bout stable. out_ready=1 at edge -> IDLE (out_valid=0 next).
//   - Latency: accept at edge k -> out_valid high after edge k+STEPS. Throughput 1 op per
//     STEPS+2 cycles with out_ready tied high (IDLE cycle between ops; in_ready=0 in DONE).
//   - Inputs a, b, bin ignored outside the accept edge; in_valid ignored when in_ready=0.
//   - Cell equations per bit: d = x ^ y ^ br; bo = (~x & y) | (~x & br) | (y & br).
//   - DIGIT==WIDTH: STEPS=1, RUN lasts one cycle.
// CONFIGURATION
//   SERIAL_SUB_SAT_EN defined: when final bout=1, diff presented as 0 (unsigned floor
//     saturation); bout still 1. Undefined: diff is the wrapped two's-complement result.
//   Saturation applied at the RUN->DONE transition; no added latency either way.
// STRUCTURE
//   serial_sub_pkg: state_t enum {IDLE, RUN, DONE}; function clog2 for count width;
//     localparam-check helper for WIDTH % DIGIT == 0.
//   Sub-module fs_digit #(DIGIT): combinational DIGIT-bit ripple full-subtractor
//     (x, y, br_in -> d, br_out); instantiated once in serial_subtractor.
// TESTING
//   1. W=8,D=1: a=0x35,b=0x12,bin=0 -> after 8 RUN cycles diff=0x23,bout=0,out_valid=1.
//   2. W=8,D=1: a=0x00,b=0x01,bin=0 -> diff=0xFF,bout=1 (SERIAL_SUB_SAT_EN: diff=0x00,bout=1).
//   3. W=8,D=1: a=0xFF,b=0xFF,bin=1 -> diff=0xFF,bout=1; a=0x80,b=0x7F,bin=1 -> 0x00,bout=0.
//   4. Backpressure: out_ready=0 for 5 cycles in DONE -> diff/bout/out_valid held, in_ready=0,
//      in_valid pulses ignored; out_ready=1 -> IDLE next cycle, in_ready=1.
//   5. rst=1 on 3rd RUN cycle -> out_valid stays 0, diff=0, in_ready=1 next cycle; new op correct.
//   6. W=8,D=4 and W=16,D=2: 1000 random ops incl. bin=1 vs model a-b-bin; latency = STEPS.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// ============================================================================
// Module  : serial_subtractor_pkg
// Purpose : Shared types and elaboration helpers for the serial subtractor.
//           Provides the FSM state encoding, a ceiling-log2 for counter
//           sizing and a configuration check (WIDTH divisible by DIGIT).
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_subtractor_pkg;

  // Explicit 2-bit encoding keeps the state register width fixed.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Legal configuration: non-empty operands, digit evenly divides width.
  function automatic bit cfg_ok(input int width, input int digit);
    return (width >= 1) && (digit >= 1) && (digit <= width) && ((width % digit) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module  : serial_subtractor_if
// Purpose : Ready/valid operand and result bundle for serial_subtractor.
// Signals : in_valid/in_ready, a, b, bin      - operand handshake
//           out_valid/out_ready, diff, bout   - result handshake
//           busy                              - operation in progress
// Modports: master (operand source / result sink), slave (the subtractor)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, busy
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, busy
  );

endinterface

`default_nettype wire

// File: rtl/serial_subtractor_fs_digit.sv
// ============================================================================
// Module  : fs_digit
// Purpose : Combinational DIGIT-bit ripple full-subtractor, x - y - br_i.
// Ports   : x_i  [DIGIT] minuend digit
//           y_i  [DIGIT] subtrahend digit
//           br_i         borrow into bit 0
//           d_o  [DIGIT] difference digit
//           br_o         borrow out of the top bit
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fs_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x_i,
  input  logic [DIGIT-1:0] y_i,
  input  logic             br_i,
  output logic [DIGIT-1:0] d_o,
  output logic             br_o
);

  always_comb begin : p_ripple
    logic br;
    br   = br_i;
    d_o  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      d_o[i] = x_i[i] ^ y_i[i] ^ br;
      br     = (~x_i[i] & y_i[i]) | (~x_i[i] & br) | (y_i[i] & br);
    end
    br_o = br;
  end

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Purpose : Multi-cycle unsigned subtractor, diff = a - b - bin (mod 2^WIDTH),
//           processed LSB-first DIGIT bits per cycle with a registered borrow.
//           One operation in flight; ready/valid on both sides.
// Ports   : clk  - clock, rising edge
//           rst  - synchronous active-high reset (aborts any operation)
//           bus  - serial_subtractor_if.slave (operands, result, busy)
// Params  : WIDTH - operand/result width; DIGIT - bits per cycle (divides WIDTH)
// Config  : SERIAL_SUB_SAT_EN - when defined, a final borrow forces diff to 0
//           (unsigned floor saturation); bout still reports the borrow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int  STEPS  = WIDTH / DIGIT;
  localparam int  CNT_W  = (clog2(STEPS) < 1) ? 1 : clog2(STEPS);
  localparam bit  CFG_OK = cfg_ok(WIDTH, DIGIT);

  if (!CFG_OK) begin : g_bad_cfg
    $error("serial_subtractor: DIGIT must evenly divide WIDTH");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, diff_q;
  logic               borrow_q, bout_q;

  logic [DIGIT-1:0]   cell_d;
  logic               cell_br;
  logic [WIDTH-1:0]   diff_shift;
  logic [WIDTH-1:0]   diff_final;
  logic               accept;
  logic               last_step;

  fs_digit #(.DIGIT(DIGIT)) u_cell (
    .x_i  (a_sh_q[DIGIT-1:0]),
    .y_i  (b_sh_q[DIGIT-1:0]),
    .br_i (borrow_q),
    .d_o  (cell_d),
    .br_o (cell_br)
  );

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign last_step = (state_q == RUN) && (count_q == CNT_W'(STEPS - 1));

  // New digit enters at the MSB end, so after STEPS shifts the first digit
  // computed has reached bit 0.  DIGIT==WIDTH degenerates to a plain load.
  assign diff_shift = (diff_q >> DIGIT) | (WIDTH'(cell_d) << (WIDTH - DIGIT));

`ifdef SERIAL_SUB_SAT_EN
  assign diff_final = cell_br ? '0 : diff_shift;
`else
  assign diff_final = diff_shift;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_step)     state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE:    bus.in_ready = 1'b1;
      RUN:     bus.busy     = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
    end else if (accept) begin
      a_sh_q   <= bus.a;
      b_sh_q   <= bus.b;
      borrow_q <= bus.bin;
      count_q  <= '0;
    end else if (state_q == RUN) begin
      a_sh_q   <= a_sh_q >> DIGIT;
      b_sh_q   <= b_sh_q >> DIGIT;
      borrow_q <= cell_br;
      count_q  <= count_q + 1'b1;
      diff_q   <= last_step ? diff_final : diff_shift;
      if (last_step) begin
        bout_q <= cell_br;
      end
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

`default_nettype wire
